// File: rtl/wdt_pkg.sv
// Shared types and constants for the multi-channel watchdog.
// Optional feature macro: WDT_WINDOW_EN (early-kick window check).
package wdt_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} wdt_state_t;

  localparam int NUM_CH_DEF     = 4;
  localparam int CNT_W_DEF      = 32;
  localparam int PRESCALE_W_DEF = 8;
  localparam int MAX_CNT_W      = 64;

  // All-ones pattern of width w, used as the timeout reset value.
  function automatic logic [MAX_CNT_W-1:0] timeout_rst(input int w);
    logic [MAX_CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_CNT_W; i++)
      if (i < w) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: FSM, saturating counter, timeout and window registers.
// With WDT_WINDOW_EN defined, early kicks (cnt < window) are rejected.
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             kick,
  input  logic             tick,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_window,
  output logic             wto,
  output logic             wto_nxt,
  output logic             kick_err
);

  localparam logic [CNT_W-1:0] TO_RST = CNT_W'(timeout_rst(CNT_W));

  wdt_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] timeout_r;
  logic             win_bad;

`ifdef WDT_WINDOW_EN
  logic [CNT_W-1:0] window_r;

  assign win_bad = (window_r != '0) && (cnt < window_r);

  // Window register and the one-cycle rejected-kick pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      window_r <= '0;
      kick_err <= 1'b0;
    end else begin
      if (cfg_we) window_r <= cfg_window;
      kick_err <= (state == COUNT) && en && kick && win_bad;
    end
  end
`else
  logic unused_win;
  assign unused_win = ^cfg_window;
  assign win_bad    = 1'b0;
  assign kick_err   = 1'b0;
`endif

  // Next state / counter; priority is disable > kick > expiry > increment.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en) state_nxt = COUNT;
      end
      COUNT: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (kick) begin
          cnt_nxt = '0;
          if (win_bad) state_nxt = EXPIRED;
        end else if (tick) begin
          if (cnt >= timeout_r) begin
            state_nxt = EXPIRED;
            cnt_nxt   = '0;
          end else if (cnt != '1) begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      EXPIRED: begin
        cnt_nxt = '0;
        if (!en)       state_nxt = IDLE;
        else if (kick) state_nxt = COUNT;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign wto_nxt = (state_nxt == EXPIRED);

  // State, counter, timeout flag and timeout register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wto       <= 1'b0;
      timeout_r <= TO_RST;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      wto   <= wto_nxt;
      if (cfg_we) timeout_r <= cfg_timeout;
    end
  end

endmodule

// File: rtl/wdt_multi.sv
// Multi-channel watchdog: shared prescaler, NUM_CH channel instances,
// registered OR of all timeout flags.
// Optional feature macro: WDT_WINDOW_EN (handled inside wdt_channel).
module wdt_multi
  import wdt_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_CH-1:0]                           ch_en,
  input  logic [NUM_CH-1:0]                           ch_kick,
  input  logic [PRESCALE_W-1:0]                       prescale,
  input  logic                                        cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_sel,
  input  logic [CNT_W-1:0]                            cfg_timeout,
  input  logic [CNT_W-1:0]                            cfg_window,
  output logic [NUM_CH-1:0]                           wto,
  output logic                                        wto_any,
  output logic [NUM_CH-1:0]                           kick_err
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  tick;
  logic [NUM_CH-1:0]     wto_nxt;

  // >= rather than == so a lowered prescale ticks immediately.
  assign tick = (pre_cnt >= prescale);

  // Free-running prescaler, independent of channel enables.
  always_ff @(posedge clk) begin
    if (rst)       pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Out-of-range cfg_sel matches no channel, so the write is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wdt_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (ch_en[i]),
      .kick       (ch_kick[i]),
      .tick       (tick),
      .cfg_we     (cfg_we && (cfg_sel == SEL_W'(i))),
      .cfg_timeout(cfg_timeout),
      .cfg_window (cfg_window),
      .wto        (wto[i]),
      .wto_nxt    (wto_nxt[i]),
      .kick_err   (kick_err[i])
    );
  end

  // Registered from the channels' next-state flags so it aligns with wto.
  always_ff @(posedge clk) begin
    if (rst) wto_any <= 1'b0;
    else     wto_any <= |wto_nxt;
  end

endmodule

// File: tb/tb_wdt_multi.sv
// Directed bench for wdt_multi (4-channel instance plus a 3-channel
// instance for out-of-range config selects).
module tb_wdt_multi;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en, kick, wto, kerr;
  logic        wany;
  logic [7:0]  prescale;
  logic        cfg_we;
  logic [1:0]  sel;
  logic [31:0] cfg_to, cfg_win;
  logic [2:0]  en3, kick3, wto3, kerr3;
  logic        wany3, we3;
  logic [1:0]  sel3;

  int checks = 0;
  int errors = 0;
  int first_n[4];
  int first_any;
  int n;
  logic any;
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  wdt_multi dut (
    .clk(clk), .rst(rst), .ch_en(en), .ch_kick(kick), .prescale(prescale),
    .cfg_we(cfg_we), .cfg_sel(sel), .cfg_timeout(cfg_to), .cfg_window(cfg_win),
    .wto(wto), .wto_any(wany), .kick_err(kerr)
  );

  wdt_multi #(.NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .ch_en(en3), .ch_kick(kick3), .prescale(prescale),
    .cfg_we(we3), .cfg_sel(sel3), .cfg_timeout(cfg_to), .cfg_window(cfg_win),
    .wto(wto3), .wto_any(wany3), .kick_err(kerr3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic run_or(input int k);
    repeat (k) begin cyc(1); any = any | (|wto); end
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2); rst = 1'b0;
  endtask

  // Edge count until wto[idx] rises, -1 if the bound expires.
  task automatic wait_bit(input int idx, input int max, output int res);
    res = -1;
    for (int c = 1; c <= max; c++) begin
      cyc(1);
      if (wto[idx]) begin res = c; break; end
    end
  endtask

  task automatic record(input int max, input int off);
    for (int i = 0; i < 4; i++) first_n[i] = -1;
    first_any = -1;
    for (int c = 1; c <= max; c++) begin
      cyc(1);
      for (int i = 0; i < 4; i++)
        if (wto[i] && first_n[i] < 0) first_n[i] = c + off;
      if (wany && first_any < 0) first_any = c + off;
    end
  endtask

  initial begin
    rst = 1'b1; en = '0; kick = '0; prescale = '0; cfg_we = 1'b0; sel = '0;
    cfg_to = '0; cfg_win = '0; en3 = '0; kick3 = '0; we3 = 1'b0; sel3 = '0;

    // Reset values
    cyc(2);
    chk("rst_wto", 32'(wto), 0);
    chk("rst_wto_any", 32'(wany), 0);
    chk("rst_kick_err", 32'(kerr), 0);
    chk("rst_wto3", 32'(wto3), 0);
    rst = 1'b0;

    // Default all-ones timeout: no expiry within 1000 cycles
    en = 4'b0001; any = 1'b0;
    run_or(1000);
    chk("default_no_timeout", 32'(any), 0);
    en = '0; cyc(1);

    // Basic timeout: prescale 3, timeout 4 -> 20 edges from enable
    prescale = 8'd3; do_reset();
    cfg_we = 1'b1; sel = 2'd1; cfg_to = 32'd4; en = 4'b0010;
    cyc(1); cfg_we = 1'b0;
    wait_bit(1, 40, n); if (n > 0) n = n + 1;
    chk("basic_latency", 32'(n), 20);
    chk("basic_wto", 32'(wto), 32'b0010);
    chk("basic_wto_any", 32'(wany), 1);

    // Kick while expired clears wto the next cycle
    kick = 4'b0010; cyc(1); kick = '0;
    chk("exp_kick_wto", 32'(wto), 0);
    chk("exp_kick_wto_any", 32'(wany), 0);
    chk("exp_kick_err", 32'(kerr), 0);

    // Kick every 12 cycles for ~200 cycles: never expires
    any = 1'b0;
    for (int k = 0; k < 17; k++) begin
      run_or(11);
      kick = 4'b0010; run_or(1); kick = '0;
    end
    chk("kick_service", 32'(any), 0);

    // Kick on the expiring tick (edge 20) wins; next expiry 20 edges later
    do_reset();
    cfg_we = 1'b1; sel = 2'd1; cfg_to = 32'd4; en = 4'b0010;
    cyc(1); cfg_we = 1'b0;
    cyc(18);
    kick = 4'b0010; cyc(1); kick = '0;
    chk("kick_vs_tick_wto", 32'(wto), 0);
    wait_bit(1, 40, n);
    chk("kick_vs_tick_relatency", 32'(n), 20);

    // Independence: timeouts 2/5/9/0, prescale 0; expiry t+1 edges after
    // entering COUNT, i.e. t+2 edges after raising ch_en
    prescale = 8'd0; do_reset(); en = '0;
    cfg_we = 1'b1;
    sel = 2'd0; cfg_to = 32'd2; cyc(1);
    sel = 2'd1; cfg_to = 32'd5; cyc(1);
    sel = 2'd2; cfg_to = 32'd9; cyc(1);
    sel = 2'd3; cfg_to = 32'd0; cyc(1);
    cfg_we = 1'b0; en = 4'b1111;
    record(15, 0);
    chk("indep_ch0", 32'(first_n[0]), 4);
    chk("indep_ch1", 32'(first_n[1]), 7);
    chk("indep_ch2", 32'(first_n[2]), 11);
    chk("indep_ch3", 32'(first_n[3]), 2);
    chk("indep_any", 32'(first_any), 2);

    // Rewrite channel 3 to 7 while kicking all out of EXPIRED
    kick = 4'b1111; cfg_we = 1'b1; sel = 2'd3; cfg_to = 32'd7;
    cyc(1); kick = '0; cfg_we = 1'b0;
    chk("cfg_kick_wto", 32'(wto), 0);
    record(14, 1);
    chk("cfg_ch0", 32'(first_n[0]), 4);
    chk("cfg_ch1", 32'(first_n[1]), 7);
    chk("cfg_ch2", 32'(first_n[2]), 11);
    chk("cfg_ch3", 32'(first_n[3]), 9);

    // 3-channel instance: sel 3 dropped, sel 2 timeout 1 applied
    en = '0;
    we3 = 1'b1; sel3 = 2'd3; cfg_to = 32'd0; cyc(1);
    sel3 = 2'd2; cfg_to = 32'd1; cyc(1);
    we3 = 1'b0; en3 = 3'b111;
    n = -1;
    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      if (wto3[2] && n < 0) n = c;
    end
    chk("oor_ch2_latency", 32'(n), 3);
    chk("oor_others", 32'(wto3 & 3'b011), 0);
    en3 = '0;

    // Disable at cnt=5, then re-enable counts from 0
    do_reset(); prescale = 8'd0;
    cfg_we = 1'b1; sel = 2'd2; cfg_to = 32'd10; en = 4'b0100;
    cyc(1); cfg_we = 1'b0;
    cyc(5);
    en = '0; cyc(1);
    chk("disable_wto", 32'(wto), 0);
    en = 4'b0100;
    wait_bit(2, 30, n);
    chk("reenable_latency", 32'(n), 12);

    // Reset mid-count clears everything; counting restarts from 0
    kick = 4'b0100; cyc(1); kick = '0;
    cyc(5);
    rst = 1'b1; cyc(1);
    chk("midrst_wto", 32'(wto), 0);
    chk("midrst_wto_any", 32'(wany), 0);
    rst = 1'b0;
    cfg_we = 1'b1; sel = 2'd2; cfg_to = 32'd10;
    cyc(1); cfg_we = 1'b0;
    wait_bit(2, 30, n); if (n > 0) n = n + 1;
    chk("midrst_relatency", 32'(n), 12);

    // Window: window 3, timeout 10; kick at cnt=1 then at cnt=5
    en = '0; do_reset(); prescale = 8'd0;
    cfg_we = 1'b1; sel = 2'd0; cfg_to = 32'd10; cfg_win = 32'd3; en = 4'b0001;
    cyc(1); cfg_we = 1'b0; cfg_win = '0;
    cyc(1);
    kick = 4'b0001; cyc(1); kick = '0;
`ifdef WDT_WINDOW_EN
    exp_v = 32'd1;
`else
    exp_v = 32'd0;
`endif
    chk("win_early_err", 32'(kerr), exp_v);
    chk("win_early_wto", 32'(wto), exp_v);
    cyc(1);
    chk("win_err_one_cycle", 32'(kerr), 0);
    kick = 4'b0001; cyc(1); kick = '0;
    chk("win_recover_wto", 32'(wto), 0);
    cyc(5);
    kick = 4'b0001; cyc(1); kick = '0;
    chk("win_late_err", 32'(kerr), 0);
    chk("win_late_wto", 32'(wto), 0);
    wait_bit(0, 30, n);
    chk("win_late_latency", 32'(n), 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wdt_multi.md
# wdt_multi

Multi-channel watchdog timer: the parametrised successor to the single-channel WDT. It provides NUM_CH independent watchdog counters, all driven by one shared programmable prescaler. Each channel has its own timeout, kick and enable. The block sits beside the system bus slave that owns the watchdog register map and drives per-channel timeout flags toward the reset/interrupt controller. It runs entirely in one clock domain; no clock-crossing logic.

## Interface
Parameters:
- NUM_CH, 4, number of independent watchdog channels (1..16)
- CNT_W, 32, width of channel counters, timeout and window values
- PRESCALE_W, 8, width of the prescaler divide value

Ports:
- clk  in  1  block clock
- rst  in  1  reset; synchronous, active-high (sampled on posedge clk only)
- ch_en  in  NUM_CH  per-channel enable (level)
- ch_kick  in  NUM_CH  per-channel kick/service pulse (one cycle per kick)
- prescale  in  PRESCALE_W  tick period minus one; 0 gives a tick every cycle
- cfg_we  in  1  write strobe for the channel configuration
- cfg_sel  in  $clog2(NUM_CH) (min 1)  channel selected by cfg_we
- cfg_timeout  in  CNT_W  timeout value written on cfg_we
- cfg_window  in  CNT_W  early-kick window written on cfg_we (ignored without WDT_WINDOW_EN)
- wto  out  NUM_CH  per-channel timeout flag (level, registered)
- wto_any  out  1  OR of wto, registered in the same cycle as wto
- kick_err  out  NUM_CH  one-cycle pulse for a rejected kick

## Operation
- Prescaler:
  - pre_cnt counts 0..prescale; tick=1 for the cycle in which pre_cnt >= prescale, and pre_cnt then returns to 0.
  - It runs freely regardless of channel enables.
  - Lowering prescale below the current pre_cnt causes a tick on the next cycle.
- Per-channel FSM, states IDLE, COUNT, EXPIRED:
  - IDLE: cnt=0, wto=0. ch_en=1 moves the channel to COUNT.
  - COUNT:
    - ch_en=0 moves to IDLE.
    - ch_kick sets cnt to 0.
    - Otherwise, on tick with cnt >= timeout, the channel moves to EXPIRED and wto goes to 1.
    - Otherwise, on tick, cnt = cnt+1. cnt saturates at all-ones and never wraps.
  - EXPIRED: wto held at 1, cnt=0.
    - ch_kick clears wto and moves to COUNT.
    - ch_en=0 moves to IDLE.
- Priority within a channel in one cycle: ch_en=0 > kick > expiry > increment.
- A kick in COUNT is handled as follows:
  - When the kick arrives in the same cycle as an expiring tick, the kick wins and no timeout occurs.
  - Kicks while in IDLE are ignored with no error.
- Configuration writes:
  - cfg_we writes timeout and window for channel cfg_sel, effective from the next cycle.
  - A cfg_sel >= NUM_CH write is dropped.
  - Writes do not reset cnt. A new timeout at or below the current cnt expires on the next tick.
- Timeout 0: the channel expires on the first tick after entering COUNT or after a kick.

## Timing
- Reset values:
  - wto, wto_any, kick_err, every cnt, and pre_cnt are all 0.
  - Every channel FSM is IDLE.
  - Every timeout is all-ones and every window is 0.
- Kick to cnt=0: one cycle.
- Expiring tick to wto=1: one cycle, registered. wto_any is asserted in the same cycle as wto.
- Time from kick to timeout: (timeout+1) ticks, i.e. (timeout+1)*(prescale+1) cycles, ±1 cycle of prescaler phase.
- kick_err pulses for exactly one cycle, in the cycle after the offending kick.
- rst asserted mid-count returns every channel to reset state on the next posedge. It has no effect between edges.

## Configuration
- WDT_WINDOW_EN defined:
  - A kick in COUNT with cnt < window is rejected. The channel moves to EXPIRED, wto=1, and kick_err pulses.
  - window=0 disables the check for that channel.
- WDT_WINDOW_EN undefined:
  - Window registers are not instantiated and cfg_window is ignored.
  - kick_err is tied to 0. All kicks in COUNT/EXPIRED are accepted.

## Structure
- Package wdt_pkg holds:
  - the typedef enum logic [1:0] wdt_state_t {IDLE, COUNT, EXPIRED};
  - the default parameter constants;
  - the all-ones timeout reset constant as a function of CNT_W.
- Sub-module wdt_channel holds one FSM, counter, timeout and window register, and is instantiated NUM_CH times via generate.
- The prescaler and the wto_any OR-reduction live in the top module, wdt_multi.

## Test plan
- Reset and defaults: assert rst for 2 cycles, hold ch_en=0 → wto=0, wto_any=0, kick_err=0. With ch_en[0]=1 and no kicks for 1000 cycles, there is no timeout (timeout=all-ones).
- Basic timeout: prescale=3, timeout[1]=4, raise ch_en[1] → wto[1]=1 after 20±1 cycles and wto_any=1; other channels stay 0.
- Kick service: same config as the basic timeout, kick every 12 cycles for 200 cycles → wto[1] never set. A kick in the same cycle as the expiring tick suppresses the timeout. A kick while EXPIRED clears wto[1] the next cycle.
- Independence and config: NUM_CH=4, timeouts 2/5/9/0, prescale=0, all enabled → each wto asserts at cycles 3/6/10/1. A write with cfg_sel=3 and timeout 7 changes only channel 3. An out-of-range cfg_sel on NUM_CH=3 changes nothing.
- Disable and reset mid-operation: dropping ch_en[2] with cnt=5 gives cnt=0 and wto[2]=0 the next cycle. rst during COUNT clears all state; re-enabling counts again from 0.
- Window (WDT_WINDOW_EN): window=3, timeout=10, prescale=0. A kick at cnt=1 gives kick_err=1 for one cycle and wto=1. A kick at cnt=5 is accepted. The build without the macro accepts both kicks and kick_err stays 0.
